// File: rtl/sram_bus_arbiter.sv
// Shares the single SRAM-like bus between instruction fetch and load/store.
// Handles one transaction at a time (address phase, then data phase) and alternates grants on ties.
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ready,
    input  logic              data_en,
    input  logic              data_we,
    input  logic [3:0]        data_sel,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_req
);

    typedef enum logic [1:0] {StIdle, StAddr, StWait} state_e;
    typedef enum logic {GntInst, GntData} gnt_e;

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              last_q, last_d;
    logic              wr_q, wr_d;
    logic              inst_ready_q, inst_ready_d;
    logic              data_ready_q, data_ready_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

    logic inst_elig, data_elig;

    function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_to_size = 2'd0;
            4'b0011, 4'b1100:                   sel_to_size = 2'd1;
            default:                            sel_to_size = 2'd2;
        endcase
    endfunction

    // A requester still holding en during its ready pulse must not be re-granted.
    assign inst_elig = inst_en & ~inst_ready_q;
    assign data_elig = data_en & ~data_ready_q;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        wr_d         = wr_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (inst_elig && data_elig) begin
                    gnt_d = (last_q == GntInst) ? GntData : GntInst;
                end else if (data_elig) begin
                    gnt_d = GntData;
                end else if (inst_elig) begin
                    gnt_d = GntInst;
                end
                if (inst_elig || data_elig) begin
                    last_d  = gnt_d;
                    wr_d    = (gnt_d == GntData) ? data_we : 1'b0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (bus_addr_ok) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus_data_ok) begin
                    if (gnt_q == GntData) begin
                        data_ready_d = 1'b1;
                        if (!wr_q) begin
                            data_rdata_d = bus_rdata;
                        end
                    end else begin
                        inst_ready_d = 1'b1;
                        inst_rdata_d = bus_rdata;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            gnt_q        <= GntInst;
            last_q       <= GntInst;
            wr_q         <= 1'b0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            wr_q         <= wr_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Address-phase fields follow the granted requester's live inputs.
    always_comb begin
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (state_q == StAddr) begin
            bus_req = 1'b1;
            if (gnt_q == GntData) begin
                bus_wr    = data_we;
                bus_size  = sel_to_size(data_sel);
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end else begin
                bus_size  = 2'd2;
                bus_addr  = inst_addr;
            end
        end
    end

    assign inst_ready = inst_ready_q;
    assign data_ready = data_ready_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign stall_req  = (inst_en & ~inst_ready_q) | (data_en & ~data_ready_q);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: single load/store, contention, address stall,
// held enable during ready, and reset during the data phase.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_en;
    logic        data_we;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stall_req;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_en     (inst_en),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_ready  (inst_ready),
        .data_en     (data_en),
        .data_we     (data_we),
        .data_sel    (data_sel),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_ready  (data_ready),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .stall_req   (stall_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait transaction; returns in the ready-pulse cycle.
    task automatic txn(input string tag, input logic is_data, input logic [31:0] addr,
                       input logic [31:0] rd);
        cyc();
        chk({tag, "_req"}, 32'(bus_req), 32'd1);
        chk({tag, "_addr"}, bus_addr, addr);
        chk({tag, "_size"}, 32'(bus_size), 32'd2);
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        cyc();
        bus_data_ok = 1'b0;
        chk({tag, "_iready"}, 32'(inst_ready), 32'(!is_data));
        chk({tag, "_dready"}, 32'(data_ready), 32'(is_data));
        chk({tag, "_rdata"}, is_data ? data_rdata : inst_rdata, rd);
    endtask

    logic [3:0] sel_tab [5];
    logic [1:0] size_tab [5];

    initial begin
        sel_tab[0] = 4'b0011; size_tab[0] = 2'd1;
        sel_tab[1] = 4'b0101; size_tab[1] = 2'd2;
        sel_tab[2] = 4'b1000; size_tab[2] = 2'd0;
        sel_tab[3] = 4'b0010; size_tab[3] = 2'd0;
        sel_tab[4] = 4'b0100; size_tab[4] = 2'd0;

        rst = 1'b0; inst_en = 1'b0; inst_addr = '0; data_en = 1'b0; data_we = 1'b0;
        data_sel = '0; data_addr = '0; data_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_iready", 32'(inst_ready), 32'd0);
        chk("rst_dready", 32'(data_ready), 32'd0);
        chk("rst_irdata", inst_rdata, 32'd0);
        chk("rst_drdata", data_rdata, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);

        // Single byte load
        data_en = 1'b1; data_we = 1'b0; data_sel = 4'b0001; data_addr = 32'h8000_0003;
        #1;
        chk("ld_stall_idle", 32'(stall_req), 32'd1);
        chk("ld_req_idle", 32'(bus_req), 32'd0);
        cyc();
        chk("ld_req", 32'(bus_req), 32'd1);
        chk("ld_size", 32'(bus_size), 32'd0);
        chk("ld_addr", bus_addr, 32'h8000_0003);
        chk("ld_wr", 32'(bus_wr), 32'd0);
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0;
        chk("ld_req_wait", 32'(bus_req), 32'd0);
        chk("ld_stall_wait", 32'(stall_req), 32'd1);
        cyc();
        chk("ld_noready_early", 32'(data_ready), 32'd0);
        bus_data_ok = 1'b1; bus_rdata = 32'hAABB_CCDD;
        cyc();
        bus_data_ok = 1'b0;
        chk("ld_ready", 32'(data_ready), 32'd1);
        chk("ld_rdata", data_rdata, 32'hAABB_CCDD);
        chk("ld_stall_ready", 32'(stall_req), 32'd0);
        chk("ld_req_ready", 32'(bus_req), 32'd0);
        data_en = 1'b0;
        cyc();
        chk("ld_ready_once", 32'(data_ready), 32'd0);
        chk("ld_req_after", 32'(bus_req), 32'd0);

        // Store halfword
        data_en = 1'b1; data_we = 1'b1; data_sel = 4'b1100; data_addr = 32'h0000_0100;
        data_wdata = 32'h1234_5678;
        cyc();
        chk("st_req", 32'(bus_req), 32'd1);
        chk("st_wr", 32'(bus_wr), 32'd1);
        chk("st_size", 32'(bus_size), 32'd1);
        chk("st_wdata", bus_wdata, 32'h1234_5678);
        bus_addr_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        cyc();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        cyc();
        bus_data_ok = 1'b0;
        chk("st_ready", 32'(data_ready), 32'd1);
        chk("st_rdata_kept", data_rdata, 32'hAABB_CCDD);
        data_en = 1'b0; data_we = 1'b0;
        cyc();
        chk("st_ready_once", 32'(data_ready), 32'd0);

        // Contention from reset: D, I, D, I
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        inst_en = 1'b1; inst_addr = 32'h0000_1000;
        data_en = 1'b1; data_we = 1'b0; data_sel = 4'b1111; data_addr = 32'h0000_2000;
        txn("c0_d", 1'b1, 32'h0000_2000, 32'h1111_1111);
        txn("c1_i", 1'b0, 32'h0000_1000, 32'h2222_2222);
        txn("c2_d", 1'b1, 32'h0000_2000, 32'h3333_3333);
        txn("c3_i", 1'b0, 32'h0000_1000, 32'h4444_4444);
        inst_en = 1'b0; data_en = 1'b0;
        cyc();
        chk("c_idle_req", 32'(bus_req), 32'd0);

        // Address phase held off for 4 cycles; then inst_en held through the ready pulse
        inst_en = 1'b1; inst_addr = 32'h0000_3000;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("as_req", 32'(bus_req), 32'd1);
            chk("as_addr", bus_addr, 32'h0000_3000);
            chk("as_size", 32'(bus_size), 32'd2);
            cyc();
        end
        bus_addr_ok = 1'b1;
        #1;
        chk("as_req_accept", 32'(bus_req), 32'd1);
        cyc();
        bus_addr_ok = 1'b0;
        chk("as_req_drop", 32'(bus_req), 32'd0);
        bus_data_ok = 1'b1; bus_rdata = 32'h5566_7788;
        cyc();
        bus_data_ok = 1'b0;
        chk("as_iready", 32'(inst_ready), 32'd1);
        chk("as_irdata", inst_rdata, 32'h5566_7788);
        chk("as_stall_ready", 32'(stall_req), 32'd0);
        cyc();
        inst_en = 1'b0;
        chk("held_no_reissue", 32'(bus_req), 32'd0);
        chk("held_iready_once", 32'(inst_ready), 32'd0);
        cyc();
        chk("held_no_reissue2", 32'(bus_req), 32'd0);

        // Size map sweep in the address phase, then reset during the data phase
        data_en = 1'b1; data_we = 1'b0; data_sel = 4'b0011; data_addr = 32'h0000_0044;
        cyc();
        for (int i = 0; i < 5; i++) begin
            data_sel = sel_tab[i];
            #1;
            chk("size_map", 32'(bus_size), 32'(size_tab[i]));
        end
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1; data_en = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999;
        #1;
        chk("rw_req", 32'(bus_req), 32'd0);
        cyc();
        bus_data_ok = 1'b0;
        chk("rw_dready", 32'(data_ready), 32'd0);
        chk("rw_iready", 32'(inst_ready), 32'd0);
        chk("rw_drdata", data_rdata, 32'd0);
        chk("rw_irdata", inst_rdata, 32'd0);
        chk("rw_req_after", 32'(bus_req), 32'd0);
        cyc();
        chk("rw_dready2", 32'(data_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Sequences the CPU's single SRAM-like memory bus and shares it between the instruction-fetch requester and the load/store (MEM) requester.
- Allows one outstanding transaction at a time.
- Returns raw 32-bit read words; byte/halfword extraction and sign extension happen in the write-back stage.
- Drives a pipeline stall request while any enabled access is incomplete.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-low
inst_en  in  1  fetch request (level, held until inst_ready)
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  fetched word (registered)
inst_ready  out  1  one-cycle completion pulse
data_en  in  1  load/store request (level, held until data_ready)
data_we  in  1  1 = store, 0 = load
data_sel  in  4  byte lanes
data_addr  in  ADDR_W  access address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  loaded word, raw (registered)
data_ready  out  1  one-cycle completion pulse
bus_req  out  1  bus address-phase request
bus_wr  out  1  write
bus_size  out  2  0 = byte, 1 = half, 2 = word
bus_addr  out  ADDR_W  address
bus_wdata  out  DATA_W  write data
bus_addr_ok  in  1  address accepted
bus_data_ok  in  1  data phase complete
bus_rdata  in  DATA_W  read data
stall_req  out  1  pipeline stall

Behaviour:
- Reset (rst==0 at a clk edge):
  - state = IDLE, last_grant = INST.
  - inst_ready, data_ready = 0; inst_rdata, data_rdata = 0.
  - Bus outputs are combinational from state and the latched grant: bus_req = 0, others 0.
- States: IDLE, ADDR, WAIT. The granted requester (INST or DATA) is latched in gnt.
- IDLE:
  - A requester is eligible if its en=1 and its ready is not high this cycle. This blocks re-issue while the requester still holds en during its ready pulse.
  - Only one eligible: grant it.
  - Both eligible: grant the one not equal to last_grant. After reset the first tie goes to DATA.
  - On grant: latch gnt, last_grant = gnt, go to ADDR.
- ADDR:
  - bus_req = 1. bus_addr, bus_wr, bus_size, bus_wdata come from the gnt requester's live inputs.
  - INST grant: wr = 0, size = 2, wdata = 0.
  - Stays in ADDR until bus_addr_ok=1, then goes to WAIT.
  - bus_data_ok in ADDR is ignored.
- WAIT:
  - bus_req = 0.
  - On bus_data_ok=1:
    - For a read, the gnt rdata register loads bus_rdata; stores leave rdata unchanged.
    - Set gnt ready = 1 for exactly the next cycle.
    - Go to IDLE.
- Size map from data_sel:
  - 0001/0010/0100/1000 -> 0
  - 0011/1100 -> 1
  - 1111 -> 2
  - Any other value -> 2
- Latency: grant edge to addr_ok is at least 1 cycle; ready is asserted the cycle after data_ok. Minimum request-to-ready with zero-wait bus is 3 cycles.
- stall_req = (inst_en & ~inst_ready) | (data_en & ~data_ready), combinational.
- Requester dropping en mid-transaction is illegal; the transaction still completes and the ready pulse is still issued.
- Reset mid-transaction: return to IDLE immediately; a late bus_data_ok in IDLE is ignored and produces no ready.
- Ready pulses never overlap; at most one per transaction.

Test Plan:
- Single load: data_en=1, we=0, sel=0001, addr=0x80000003. Bus gives addr_ok in the ADDR cycle, data_ok 2 cycles later with rdata=0xAABBCCDD -> bus_size=0, bus_addr=0x80000003, data_rdata=0xAABBCCDD, one data_ready pulse, stall_req high until the pulse.
- Store half: we=1, sel=1100, wdata=0x12345678 -> bus_wr=1, bus_size=1, bus_wdata=0x12345678; data_rdata unchanged; one data_ready pulse.
- Contention: inst_en and data_en high together from reset -> DATA granted first, INST next. Repeat both with continuous requests -> grants alternate D, I, D, I.
- addr_ok held low 4 cycles -> bus_req stays high with stable fields for 4 cycles, then drops after acceptance.
- Held en during ready pulse: inst_en held one extra cycle after inst_ready -> no duplicate bus transaction issued.
- Reset in WAIT: rst=0 for one cycle, then data_ok arrives -> no ready pulse, outputs 0, state IDLE.
